// File: rtl/sfx_scheduler_if.sv
// Bundle between the game-event side and the sound-effect scheduler.
// The master side (game FSM) raises request/abort pulses; the slave side
// (scheduler) drives the tone generator controls and status.
interface sfx_scheduler_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0] req_pulse;
  logic            abort;
  logic            tone_en;
  logic [25:0]     half_period;
  logic            busy;
  logic [1:0]      active_id;
  logic [1:0]      note_idx;
  logic            done;

  modport master (
    output req_pulse, abort,
    input  tone_en, half_period, busy, active_id, note_idx, done
  );

  modport slave (
    input  req_pulse, abort,
    output tone_en, half_period, busy, active_id, note_idx, done
  );
endinterface

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: latches event pulses, grants the single tone
// generator to the lowest-numbered pending requester and plays that
// requester's note sequence from a fixed table.
// Optional macro SFX_GAP_EN inserts a silent gap of GAP_TICKS cycles
// between consecutive notes of a sequence.
module sfx_scheduler #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned NOTE_TICKS = 6250000,
  parameter int unsigned GAP_TICKS  = 500000
) (
  input  logic          clk,
  input  logic          rst,
  sfx_scheduler_if.slave bus
);

`ifdef SFX_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;
  localparam logic [25:0] GAP_LAST = 26'(GAP_TICKS - 1);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1} state_t;
`endif

  localparam logic [25:0] NOTE_LAST = 26'(NOTE_TICKS - 1);

  // Half-period per (requester, slot); a zero entry terminates the sequence.
  function automatic logic [25:0] note_table(input logic [1:0] id, input logic [1:0] idx);
    logic [25:0] v;
    v = 26'd0;
    case ({id, idx})
      4'b00_00: v = 26'd170648;
      4'b00_01: v = 26'd50607;
      4'b01_00: v = 26'd113636;
      4'b10_00: v = 26'd95557;
      4'b10_01: v = 26'd75844;
      4'b10_10: v = 26'd63776;
      4'b11_00: v = 26'd63776;
      4'b11_01: v = 26'd47778;
      4'b11_10: v = 26'd63776;
      4'b11_11: v = 26'd47778;
      default:  v = 26'd0;
    endcase
    return v;
  endfunction

  state_t          state;
  logic [NREQ-1:0] pending;
  logic [25:0]     cnt;
  logic            tone_en;
  logic [25:0]     half_period;
  logic            busy;
  logic [1:0]      active_id;
  logic [1:0]      note_idx;
  logic            done;

  logic [1:0]      first_id;
  logic            any_pending;
  logic [NREQ-1:0] grant_mask;
  logic [25:0]     next_hp;
  logic            last_note;

  // Fixed priority: lowest set pending index wins.
  always_comb begin
    first_id    = 2'd0;
    any_pending = |pending;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      first_id = pending[i] ? 2'(i) : first_id;
    end
    grant_mask = {{(NREQ-1){1'b0}}, 1'b1} << first_id;
  end

  // Look ahead to the next slot to decide between advancing and finishing.
  always_comb begin
    next_hp   = note_table(active_id, note_idx + 2'd1);
    last_note = (note_idx == 2'd3) || (next_hp == 26'd0);
  end

  // Main sequencer: pending latch, grant, note timing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      cnt         <= 26'd0;
      tone_en     <= 1'b0;
      half_period <= 26'd0;
      busy        <= 1'b0;
      active_id   <= 2'd0;
      note_idx    <= 2'd0;
      done        <= 1'b0;
    end else if (bus.abort) begin
      // Abort beats any request arriving on the same edge.
      state   <= IDLE;
      pending <= '0;
      cnt     <= 26'd0;
      tone_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done    <= 1'b0;
      pending <= pending | bus.req_pulse;
      case (state)
        IDLE: begin
          if (any_pending) begin
            // New pulse for the granted requester re-arms it (set wins).
            pending     <= (pending & ~grant_mask) | bus.req_pulse;
            active_id   <= first_id;
            note_idx    <= 2'd0;
            half_period <= note_table(first_id, 2'd0);
            tone_en     <= 1'b1;
            busy        <= 1'b1;
            cnt         <= 26'd0;
            state       <= PLAY;
          end else begin
            state <= IDLE;
          end
        end
        PLAY: begin
          if (cnt == NOTE_LAST) begin
            cnt <= 26'd0;
            if (last_note) begin
              state   <= IDLE;
              tone_en <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
`ifdef SFX_GAP_EN
              state   <= GAP;
              tone_en <= 1'b0;
`else
              note_idx    <= note_idx + 2'd1;
              half_period <= next_hp;
`endif
            end
          end else begin
            cnt <= cnt + 26'd1;
          end
        end
`ifdef SFX_GAP_EN
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt         <= 26'd0;
            note_idx    <= note_idx + 2'd1;
            half_period <= next_hp;
            tone_en     <= 1'b1;
            state       <= PLAY;
          end else begin
            cnt <= cnt + 26'd1;
          end
        end
`endif
        default: begin
          state   <= IDLE;
          cnt     <= 26'd0;
          tone_en <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tone_en     = tone_en;
  assign bus.half_period = half_period;
  assign bus.busy        = busy;
  assign bus.active_id   = active_id;
  assign bus.note_idx    = note_idx;
  assign bus.done        = done;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Scoreboard bench for sfx_scheduler: each scenario pushes the per-cycle
// expected outputs when it drives stimulus; a monitor pops one entry per
// clock and compares it with the DUT outputs.
module tb_sfx_scheduler;

  localparam int NT = 8;
  localparam int GT = 3;
  localparam logic [25:0] TONES [0:3][0:3] = '{
    '{26'd170648, 26'd50607, 26'd0,     26'd0},
    '{26'd113636, 26'd0,     26'd0,     26'd0},
    '{26'd95557,  26'd75844, 26'd63776, 26'd0},
    '{26'd63776,  26'd47778, 26'd63776, 26'd47778}
  };

  typedef struct packed {
    logic [7:0]  sc;
    logic [32:0] vec;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       abort;

  int unsigned checks;
  int unsigned errors;
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          sc;
  logic [25:0] last_hp;
  int          last_id;
  int          last_idx;

  sfx_scheduler_if #(.NREQ(4)) bus ();
  assign bus.req_pulse = req;
  assign bus.abort     = abort;

  sfx_scheduler #(.NREQ(4), .NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output vector {tone_en, half_period, busy, done, active_id, note_idx}.
  task automatic add(input logic te, input logic [25:0] hp, input logic bsy,
                     input logic dn, input int id, input int idx, input int n);
    exp_t e;
    e.sc  = 8'(sc);
    e.vec = {te, hp, bsy, dn, 2'(id), 2'(idx)};
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic add_idle(input int n);
    add(1'b0, last_hp, 1'b0, 1'b0, last_id, last_idx, n);
  endtask

  // Whole sequence of one requester, ending with the done cycle.
  task automatic add_seq(input int id);
    logic live;
    live = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (live && TONES[id][k] != 26'd0) begin
`ifdef SFX_GAP_EN
        if (k > 0) add(1'b0, TONES[id][k-1], 1'b1, 1'b0, id, k - 1, GT);
`endif
        add(1'b1, TONES[id][k], 1'b1, 1'b0, id, k, NT);
        last_hp  = TONES[id][k];
        last_idx = k;
      end else begin
        live = 1'b0;
      end
    end
    last_id = id;
    add(1'b0, last_hp, 1'b0, 1'b1, id, last_idx, 1);
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 400) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  // Compare one expected entry per clock, just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_eq($sformatf("sc%0d", mon_e.sc),
               64'({bus.tone_en, bus.half_period, bus.busy, bus.done,
                    bus.active_id, bus.note_idx}),
               64'(mon_e.vec));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 4'd0; abort = 1'b0;
    checks = 0; errors = 0;
    last_hp = 26'd0; last_id = 0; last_idx = 0;

    // 1: reset values, then 20 quiet idle cycles
    sc = 1;
    @(negedge clk); rst = 1'b1; add(1'b0, 26'd0, 1'b0, 1'b0, 0, 0, 1);
    @(negedge clk); rst = 1'b0; add_idle(20);
    wait_drain();

    // 2: requester 0, two notes, grant two edges after the pulse
    sc = 2;
    req = 4'b0001; add_idle(1); add_seq(0); add_idle(2);
    @(negedge clk); req = 4'd0;
    wait_drain();

    // 3: simultaneous 1 and 3, priority to 1, one idle cycle between
    sc = 3;
    req = 4'b1010; add_idle(1); add_seq(1); add_seq(3); add_idle(2);
    @(negedge clk); req = 4'd0;
    wait_drain();

    // 4: abort mid note 0 of requester 3; queued 2 and same-edge 0 dropped
    sc = 4;
    req = 4'b1000; add_idle(1);
    add(1'b1, 26'd63776, 1'b1, 1'b0, 3, 0, 5);
    add(1'b0, 26'd63776, 1'b0, 1'b0, 3, 0, 12);
    last_hp = 26'd63776; last_id = 3; last_idx = 0;
    @(negedge clk); req = 4'd0;
    @(negedge clk); req = 4'b0100;
    @(negedge clk); req = 4'd0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); abort = 1'b1; req = 4'b0001;
    @(negedge clk); abort = 1'b0; req = 4'd0;
    wait_drain();

    // 5: reset mid note of requester 2 with a same-edge request for 0
    sc = 5;
    req = 4'b0100; add_idle(1);
    add(1'b1, 26'd95557, 1'b1, 1'b0, 2, 0, 4);
    add(1'b0, 26'd0, 1'b0, 1'b0, 0, 0, 13);
    last_hp = 26'd0; last_id = 0; last_idx = 0;
    @(negedge clk); req = 4'd0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst = 1'b1; req = 4'b0001;
    @(negedge clk); rst = 1'b0; req = 4'd0;
    wait_drain();

    // 6: requester 2 full sequence (gapped when the option is built in)
    sc = 6;
    req = 4'b0100; add_idle(1); add_seq(2); add_idle(2);
    @(negedge clk); req = 4'd0;
    wait_drain();

    // 7: pulse on the grant edge re-arms the same requester
    sc = 7;
    req = 4'b0001; add_idle(1); add_seq(0); add_seq(0); add_idle(3);
    @(negedge clk); req = 4'b0001;
    @(negedge clk); req = 4'd0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
